// File: rtl/axis_frame_formatter.sv
// AXI-Stream output framer: buffers pixels in a small FIFO and regenerates tuser/tlast from its own counters.
// Optional upstream tlast checker enabled by defining FRAME_FORMATTER_TLAST_CHECK_EN.
module axis_frame_formatter #(
  parameter int DATA_WIDTH     = 24,
  parameter int DST_IMG_WIDTH  = 4096,
  parameter int DST_IMG_HEIGHT = 2160,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  line_err
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = (DST_IMG_WIDTH > 1) ? $clog2(DST_IMG_WIDTH) : 1;
  localparam int RW    = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam int TOTAL = DST_IMG_WIDTH * DST_IMG_HEIGHT;
  localparam int NW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(DST_IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DST_IMG_HEIGHT - 1);
  localparam logic [NW-1:0] IN_TOTAL = NW'(TOTAL);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q;
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [NW-1:0]         in_cnt_q;
  logic [CW-1:0]         out_col_q, out_col_d;
  logic [RW-1:0]         out_row_q, out_row_d;
  logic                  busy_q, frame_done_q;
  logic                  fifo_empty, fifo_full, push, pop, last_beat;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign s_axis_tready = (state_q == RUN) && !fifo_full && (in_cnt_q < IN_TOTAL);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = !fifo_empty;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Head is masked while empty so stale RAM contents never reach the port.
  assign m_axis_tdata = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tlast = m_axis_tvalid && (out_col_q == COL_LAST);
  assign m_axis_tuser = m_axis_tvalid && (out_col_q == '0) && (out_row_q == '0);
  assign last_beat    = pop && (out_col_q == COL_LAST) && (out_row_q == ROW_LAST);

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  always_comb begin
    out_col_d = out_col_q + CW'(1);
    out_row_d = out_row_q;
    if (out_col_q == COL_LAST) begin
      out_col_d = '0;
      out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      in_cnt_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            in_cnt_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
          end
        end
        RUN: begin
          if (push) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            in_cnt_q <= in_cnt_q + NW'(1);
          end
          if (pop) begin
            rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
          end
          if (last_beat) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FRAME_FORMATTER_TLAST_CHECK_EN
  logic [CW-1:0] in_col_q;
  logic          line_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col_q   <= '0;
      line_err_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      in_col_q   <= '0;
      line_err_q <= 1'b0;
    end else if (push) begin
      in_col_q <= (in_col_q == COL_LAST) ? '0 : in_col_q + CW'(1);
      if (s_axis_tlast != (in_col_q == COL_LAST)) line_err_q <= 1'b1;
    end
  end

  assign line_err = line_err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign line_err     = 1'b0;
`endif

endmodule
